eth_frame_builder: RTL and testbench

Streaming Ethernet/IPv4/UDP frame transmitter. It is the transmit-side counterpart of the team's frame-field extractor: it accepts one frame request (source/destination IP and port) over a valid/ready handshake. It then emits a fixed 16-word, 32-bit frame with sop/eop/valid framing and `out_ready` backpressure. Fields sit at the word positions the receive path parses: source IP in word 8, source port in word 10[31:16]. The block sits between the control logic that schedules test or reply frames and the MAC-side stream interface.

---
 rtl/eth_frame_builder.sv | 139 +++++++++++++
 tb/tb_eth_frame_builder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_builder.sv
// eth_frame_builder: builds a fixed 16-word Ethernet/IPv4/UDP frame per request
// and streams it out with sop/eop framing, backpressure and an inter-frame gap.
module eth_frame_builder #(
   parameter logic [47:0] DST_MAC = 48'h0200_0000_0002,
   parameter logic [47:0] SRC_MAC = 48'h0200_0000_0001,
   parameter int          IFG     = 2,
   parameter logic [31:0] FILL    = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] src_ip_i,
   input  logic [31:0] dst_ip_i,
   input  logic [15:0] src_port_i,
   input  logic [15:0] dst_port_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic        out_sop_o,
   output logic        out_eop_o,
   output logic [31:0] out_data_o,
   output logic [15:0] seq_o
);
   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
   state_t      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [15:0] seq_q, seq_d, cseq_q, cseq_d, sport_q, sport_d, dport_q, dport_d, gap_q, gap_d;
   logic [31:0] sip_q, sip_d, dip_q, dip_d, data_q, data_d;
   logic        valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;

   function automatic logic [31:0] word(input logic [3:0] i, input logic [31:0] sip, dip,
                                        input logic [15:0] sp, dp, sq);
      case (i)
         4'd0:    word = DST_MAC[47:16];
         4'd1:    word = {DST_MAC[15:0], SRC_MAC[47:32]};
         4'd2:    word = SRC_MAC[31:0];
         4'd3:    word = 32'h0800_4500;
         4'd4:    word = {16'd44, sq};
         4'd5:    word = 32'h4000_4011;
         4'd6:    word = 32'h0;
         4'd7:    word = 32'h0;
         4'd8:    word = sip;
         4'd9:    word = dip;
         4'd10:   word = {sp, dp};
         4'd11:   word = {16'd24, 16'h0000};
         default: word = FILL;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      seq_d   = seq_q;
      cseq_d  = cseq_q;
      sip_d   = sip_q;
      dip_d   = dip_q;
      sport_d = sport_q;
      dport_d = dport_q;
      gap_d   = gap_q;
      data_d  = data_q;
      valid_d = valid_q;
      sop_d   = sop_q;
      eop_d   = eop_q;
      case (state_q)
         IDLE: if (req_valid_i) begin
            sip_d   = src_ip_i;
            dip_d   = dst_ip_i;
            sport_d = src_port_i;
            dport_d = dst_port_i;
            cseq_d  = seq_q;
            idx_d   = 4'd0;
            data_d  = word(4'd0, src_ip_i, dst_ip_i, src_port_i, dst_port_i, seq_q);
            valid_d = 1'b1;
            sop_d   = 1'b1;
            eop_d   = 1'b0;
            state_d = SEND;
         end
         SEND: if (out_ready_i) begin
            if (idx_q == 4'd15) begin
               seq_d   = seq_q + 16'd1;
               valid_d = 1'b0;
               sop_d   = 1'b0;
               eop_d   = 1'b0;
               gap_d   = '0;
               state_d = (IFG == 0) ? IDLE : GAP;
            end else begin
               idx_d  = idx_q + 4'd1;
               data_d = word(idx_d, sip_q, dip_q, sport_q, dport_q, cseq_q);
               sop_d  = 1'b0;
               eop_d  = (idx_d == 4'd15);
            end
         end
         GAP: begin
            gap_d = gap_q + 16'd1;
            if (gap_q == 16'(IFG - 1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         seq_q   <= '0;
         cseq_q  <= '0;
         sip_q   <= '0;
         dip_q   <= '0;
         sport_q <= '0;
         dport_q <= '0;
         gap_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         seq_q   <= seq_d;
         cseq_q  <= cseq_d;
         sip_q   <= sip_d;
         dip_q   <= dip_d;
         sport_q <= sport_d;
         dport_q <= dport_d;
         gap_q   <= gap_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         sop_q   <= sop_d;
         eop_q   <= eop_d;
      end
   end

   assign req_ready_o = (state_q == IDLE);
   assign out_valid_o = valid_q;
   assign out_sop_o   = sop_q;
   assign out_eop_o   = eop_q;
   assign out_data_o  = data_q;
   assign seq_o       = seq_q;
endmodule

// File: tb/tb_eth_frame_builder.sv
// tb_eth_frame_builder: reference-model bench for eth_frame_builder (IFG=2),
// directed scenarios plus randomized requests and backpressure.
module tb_eth_frame_builder;
   localparam logic [47:0] DMAC = 48'h0200_0000_0002;
   localparam logic [47:0] SMAC = 48'h0200_0000_0001;
   localparam logic [31:0] FILLV = 32'h0000_0000;
   localparam int IFGV = 2;

   logic        clk = 0, rst_n = 0, req_valid = 0, out_ready = 1;
   logic        req_ready, out_valid, out_sop, out_eop;
   logic [31:0] src_ip = 0, dst_ip = 0, out_data;
   logic [15:0] src_port = 0, dst_port = 0, seq;

   eth_frame_builder #(.DST_MAC(DMAC), .SRC_MAC(SMAC), .IFG(IFGV), .FILL(FILLV)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .src_ip_i(src_ip), .dst_ip_i(dst_ip), .src_port_i(src_port), .dst_port_i(dst_port),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_sop_o(out_sop),
      .out_eop_o(out_eop), .out_data_o(out_data), .seq_o(seq));

   always #5 clk = ~clk;

   int n_tests = 0, n_fail = 0, cyc = 0;
   int left = 0, gap_m = 0, frames_done = 0, eop_cnt = 0, stall_cnt = 0;
   logic [15:0] m_seq = 0;
   logic [31:0] exp_w [16];
   logic [31:0] last_frame [16];
   logic [15:0] w4_hist [$];
   int sop_cyc [$];
   logic prev_sv = 0, rnd_rdy = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: an accepted request becomes a list of 16 expected words;
   // the frame drains one word per accepted beat, then IFGV idle cycles follow.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         chk("rst_valid", out_valid, 0);
         chk("rst_sop", out_sop, 0);
         chk("rst_eop", out_eop, 0);
         chk("rst_data", out_data, 0);
         chk("rst_seq", seq, 0);
         chk("rst_ready", req_ready, 1);
         left = 0; gap_m = 0; m_seq = 0; prev_sv = 0;
      end else begin
         chk("ready", req_ready, left == 0 && gap_m == 0);
         chk("seq", seq, m_seq);
         chk("valid", out_valid, left > 0);
         if (left > 0) begin
            chk($sformatf("word%0d", 16 - left), out_data, exp_w[16 - left]);
            chk("sop", out_sop, left == 16);
            chk("eop", out_eop, left == 1);
         end else begin
            chk("idle_sop", out_sop, 0);
            chk("idle_eop", out_eop, 0);
         end
         if (out_valid && out_sop && !prev_sv) sop_cyc.push_back(cyc);
         prev_sv = out_valid && out_sop;
         if (left == 0 && gap_m == 0) begin
            if (req_valid) begin
               exp_w[0] = DMAC[47:16];
               exp_w[1] = {DMAC[15:0], SMAC[47:32]};
               exp_w[2] = SMAC[31:0];
               exp_w[3] = 32'h0800_4500;
               exp_w[4] = {16'd44, m_seq};
               exp_w[5] = 32'h4000_4011;
               exp_w[6] = 32'h0;
               exp_w[7] = 32'h0;
               exp_w[8] = src_ip;
               exp_w[9] = dst_ip;
               exp_w[10] = {src_port, dst_port};
               exp_w[11] = {16'd24, 16'h0000};
               for (int i = 12; i < 16; i++) exp_w[i] = FILLV;
               left = 16;
            end
         end else if (left > 0) begin
            if (out_ready) begin
               last_frame[16 - left] = out_data;
               if (out_eop) eop_cnt++;
               left--;
               if (left == 0) begin
                  m_seq++;
                  gap_m = IFGV;
                  frames_done++;
                  w4_hist.push_back(last_frame[4][15:0]);
               end
            end else stall_cnt++;
         end else gap_m--;
      end
   end

   always @(posedge clk) begin
      #1;
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic clear_stats();
      frames_done = 0; eop_cnt = 0; stall_cnt = 0;
      w4_hist.delete(); sop_cyc.delete();
   endtask

   task automatic do_reset();
      rst_n = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      clear_stats();
   endtask

   task automatic request(input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] sp, input logic [15:0] dp);
      bit ok = 0;
      @(posedge clk); #1;
      src_ip = s; dst_ip = d; src_port = sp; dst_port = dp; req_valid = 1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (req_ready) begin ok = 1; break; end
      end
      chk("req_timeout", ok, 1);
      @(posedge clk); #1 req_valid = 0;
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (req_ready && !out_valid) begin ok = 1; break; end
      end
      chk("idle_timeout", ok, 1);
      @(posedge clk); #1;
   endtask

   task automatic wait_word(input logic [31:0] w);
      bit ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (out_valid && out_data == w) begin ok = 1; break; end
      end
      chk("word_timeout", ok, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      do_reset();
      // single frame, no stall
      request(32'hC0A8_0105, 32'hC0A8_0101, 16'h1F90, 16'h0035);
      wait_idle();
      chk("t1_w0", last_frame[0], 32'h0200_0000);
      chk("t1_w1", last_frame[1], 32'h0002_0200);
      chk("t1_w3", last_frame[3], 32'h0800_4500);
      chk("t1_w4", last_frame[4], 32'h002C_0000);
      chk("t1_w8", last_frame[8], 32'hC0A8_0105);
      chk("t1_w10", last_frame[10], 32'h1F90_0035);
      chk("t1_w11", last_frame[11], 32'h0018_0000);
      chk("t1_seq", seq, 1);
      chk("t1_eops", eop_cnt, 1);
      chk("t1_sops", sop_cyc.size(), 1);
      // backpressure at idx 8 (3 cycles) and idx 15 (1 cycle)
      clear_stats();
      request(32'hC0A8_0105, 32'hC0A8_0101, 16'h1F90, 16'h0035);
      wait_word(32'h4000_4011);
      repeat (3) @(posedge clk);
      #1 out_ready = 0;
      repeat (3) @(posedge clk);
      #1 out_ready = 1;
      repeat (7) @(posedge clk);
      #1 out_ready = 0;
      @(posedge clk);
      #1 out_ready = 1;
      wait_idle();
      chk("t2_stalls", stall_cnt, 4);
      chk("t2_eops", eop_cnt, 1);
      chk("t2_w4", last_frame[4], 32'h002C_0001);
      chk("t2_w8", last_frame[8], 32'hC0A8_0105);
      chk("t2_seq", seq, 2);
      // back-to-back with req_valid held
      do_reset();
      src_ip = 32'h0A00_0001; dst_ip = 32'h0A00_0002; src_port = 16'h1234; dst_port = 16'h5678;
      req_valid = 1;
      for (int i = 0; i < 200 && frames_done < 3; i++) @(negedge clk);
      @(posedge clk); #1 req_valid = 0;
      wait_idle();
      chk("t3_nframes", sop_cyc.size() >= 3, 1);
      chk("t3_period01", sop_cyc[1] - sop_cyc[0], 19);
      chk("t3_period12", sop_cyc[2] - sop_cyc[1], 19);
      chk("t3_w4_f0", w4_hist[0], 16'h0000);
      chk("t3_w4_f1", w4_hist[1], 16'h0001);
      // input change mid-frame
      do_reset();
      request(32'hC0A8_0105, 32'hC0A8_0101, 16'h1F90, 16'h0035);
      wait_word(32'h0000_0001);
      @(posedge clk); #1 src_ip = 32'hDEAD_BEEF;
      wait_idle();
      chk("t4_w8", last_frame[8], 32'hC0A8_0105);
      // reset mid-frame at idx 6
      request(32'hC0A8_0105, 32'hC0A8_0101, 16'h1F90, 16'h0035);
      wait_word(32'h4000_4011);
      @(posedge clk); #1 rst_n = 0;
      #1;
      chk("t5_valid_drop", out_valid, 0);
      chk("t5_eop_drop", out_eop, 0);
      chk("t5_seq", seq, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      clear_stats();
      request(32'hC0A8_0105, 32'hC0A8_0101, 16'h1F90, 16'h0035);
      wait_idle();
      chk("t5_frames", frames_done, 1);
      chk("t5_sops", sop_cyc.size(), 1);
      chk("t5_w4", last_frame[4], 32'h002C_0000);
      chk("t5_seq_after", seq, 1);
      // sequence wrap via preload
      do_reset();
      @(posedge clk); #1;
      force dut.seq_q = 16'hFFFE;
      m_seq = 16'hFFFE;
      @(posedge clk); #1;
      release dut.seq_q;
      clear_stats();
      for (int f = 0; f < 3; f++) begin
         request($urandom, $urandom, 16'($urandom), 16'($urandom));
         wait_idle();
         if (f == 1) chk("t6_seq_wrapped", seq, 16'h0000);
      end
      chk("t6_w4_a", w4_hist[0], 16'hFFFE);
      chk("t6_w4_b", w4_hist[1], 16'hFFFF);
      chk("t6_w4_c", w4_hist[2], 16'h0000);
      chk("t6_seq", seq, 16'h0001);
      // randomized requests and backpressure
      do_reset();
      rnd_rdy = 1;
      for (int n = 0; n < 25; n++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         request($urandom, $urandom, 16'($urandom), 16'($urandom));
      end
      wait_idle();
      rnd_rdy = 0;
      out_ready = 1;
      chk("t7_frames", frames_done, 25);
      chk("t7_eops", eop_cnt, 25);
      chk("t7_seq", seq, 25);
      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
